// File: rtl/srambank_arbiter_2p.sv
// srambank_arbiter_2p: two-port round-robin arbiter for one SRAM bank; define SRAMBANK_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module srambank_arbiter_2p #(
  parameter int AW = 9,
  parameter int DW = 40
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_we,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            sram_banksel,
  output logic            sram_read,
  output logic            sram_write,
  output logic [AW-1:0]   sram_addr,
  output logic [DW-1:0]   sram_wd,
  input  logic [DW-1:0]   sram_dout
);
  logic       pend_q, pend_d, owner_q, owner_d;
  logic       rsp_hs, read_ok, sel, any, rd_acc;
  logic [1:0] elig;
  assign rsp_hs  = pend_q & rsp_ready[owner_q];
  assign read_ok = ~pend_q | rsp_hs;
  assign elig    = req_valid & (req_we | {2{read_ok}});
`ifdef SRAMBANK_ARB_FIXED_PRIO_EN
  assign sel = ~elig[0];
`else
  logic last_q, last_d;
  assign sel    = &elig ? ~last_q : elig[1];
  assign last_d = any ? sel : last_q;
  always_ff @(posedge clk)
    last_q <= reset ? 1'b1 : last_d;
`endif
  assign any          = ~reset & |elig;
  assign req_ready    = any ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign sram_banksel = any;
  assign sram_write   = any & req_we[sel];
  assign sram_read    = any & ~req_we[sel];
  assign sram_addr    = any ? (sel ? req_addr[AW +: AW] : req_addr[0 +: AW]) : '0;
  assign sram_wd      = any ? (sel ? req_wdata[DW +: DW] : req_wdata[0 +: DW]) : '0;
  // a new read may replace a response that handshakes in the same cycle
  assign rd_acc    = any & ~req_we[sel];
  assign pend_d    = rd_acc | (pend_q & ~rsp_hs);
  assign owner_d   = rd_acc ? sel : owner_q;
  assign rsp_valid = pend_q ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = sram_dout;
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      owner_q <= owner_d;
    end
  end
endmodule

// File: tb/tb_srambank_arbiter_2p.sv
// tb_srambank_arbiter_2p: scoreboard bench for srambank_arbiter_2p with a behavioural bank model.
module tb_srambank_arbiter_2p;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [17:0] req_addr;
  logic [79:0] req_wdata;
  logic [39:0] rsp_rdata, sram_wd, sram_dout;
  logic        sram_banksel, sram_read, sram_write;
  logic [8:0]  sram_addr;
  logic [39:0] mem [512];
  int n_cmp = 0, n_bad = 0;

  typedef struct {logic [1:0] g; logic we; logic [8:0] a; logic [39:0] d;} gexp_t;
  typedef struct {logic [1:0] v; logic [39:0] d;} rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];

  always #5 clk = ~clk;

  srambank_arbiter_2p dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sram_banksel(sram_banksel), .sram_read(sram_read), .sram_write(sram_write),
    .sram_addr(sram_addr), .sram_wd(sram_wd), .sram_dout(sram_dout)
  );

  always @(posedge clk)
    if (sram_banksel) begin
      if (sram_write) mem[sram_addr] <= sram_wd;
      if (sram_read) sram_dout <= mem[sram_addr];
    end

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [1:0] we, input logic [8:0] a0, input logic [8:0] a1,
                         input logic [39:0] d0, input logic [39:0] d1);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic pushg(input logic [1:0] g, input logic we, input logic [8:0] a, input logic [39:0] d);
    gexp_t e;
    e.g = g; e.we = we; e.a = a; e.d = d;
    gq.push_back(e);
  endtask

  task automatic pushr(input logic [1:0] v, input logic [39:0] d);
    rexp_t e;
    e.v = v; e.d = d;
    rq.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    gexp_t g;
    rexp_t r;
    if (req_ready !== 2'b00) begin
      if (gq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_grant: got req_ready=%b want none", req_ready);
      end else begin
        g = gq.pop_front();
        chk("grant_port", {38'b0, req_ready}, {38'b0, g.g});
        chk("sram_ctl", {37'b0, sram_banksel, sram_write, sram_read}, {37'b0, 1'b1, g.we, ~g.we});
        chk("sram_addr", {31'b0, sram_addr}, {31'b0, g.a});
        if (g.we) chk("sram_wd", sram_wd, g.d);
      end
    end
    if ((rsp_valid & rsp_ready) !== 2'b00) begin
      if (rq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b want none", rsp_valid);
      end else begin
        r = rq.pop_front();
        chk("rsp_port", {38'b0, rsp_valid}, {38'b0, r.v});
        chk("rsp_data", rsp_rdata, r.d);
      end
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = {8'hC0, 23'h0, i[8:0]};
    sram_dout = '0;
    rsp_ready = 2'b00;
    set_req(2'b11, 2'b00, 9'h001, 9'h002, '0, '0);
    repeat (2) begin
      tick();
      chk("rst_req_ready", {38'b0, req_ready}, 40'h0);
      chk("rst_banksel", {39'b0, sram_banksel}, 40'h0);
      chk("rst_rsp_valid", {38'b0, rsp_valid}, 40'h0);
    end
    reset = 1'b0;
    rsp_ready = 2'b11;
    set_req(2'b01, 2'b01, 9'h005, 9'h000, 40'hAA55AA55AA, '0);
    pushg(2'b01, 1'b1, 9'h005, 40'hAA55AA55AA);
    tick();
    set_req(2'b10, 2'b00, 9'h000, 9'h005, '0, '0);
    pushg(2'b10, 1'b0, 9'h005, '0);
    pushr(2'b10, 40'hAA55AA55AA);
    tick();
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    #1 chk("t2_rsp_valid", {38'b0, rsp_valid}, 40'h2);
    tick();
    set_req(2'b11, 2'b00, 9'h020, 9'h021, '0, '0);
    for (int k = 0; k < 4; k++) begin
`ifdef SRAMBANK_ARB_FIXED_PRIO_EN
      pushg(2'b01, 1'b0, 9'h020, '0);
      pushr(2'b01, 40'hC000000020);
`else
      pushg(k[0] ? 2'b10 : 2'b01, 1'b0, k[0] ? 9'h021 : 9'h020, '0);
      pushr(k[0] ? 2'b10 : 2'b01, k[0] ? 40'hC000000021 : 40'hC000000020);
`endif
      tick();
    end
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    rsp_ready = 2'b00;
    set_req(2'b01, 2'b00, 9'h010, 9'h000, '0, '0);
    pushg(2'b01, 1'b0, 9'h010, '0);
    pushr(2'b01, 40'hC000000010);
    tick();
    set_req(2'b11, 2'b10, 9'h011, 9'h010, '0, 40'h1234567890);
    pushg(2'b10, 1'b1, 9'h010, 40'h1234567890);
    #1 chk("t4_rsp_valid", {38'b0, rsp_valid}, 40'h1);
    chk("t4_rsp_hold", rsp_rdata, 40'hC000000010);
    repeat (3) begin
      tick();
      set_req(2'b01, 2'b00, 9'h011, 9'h000, '0, '0);
      #1 chk("t4_rsp_valid", {38'b0, rsp_valid}, 40'h1);
      chk("t4_rsp_hold", rsp_rdata, 40'hC000000010);
      chk("t4_read_blocked", {38'b0, req_ready}, 40'h0);
    end
    tick();
    rsp_ready = 2'b01;
    pushg(2'b01, 1'b0, 9'h011, '0);
    pushr(2'b01, 40'hC000000011);
    tick();
    set_req(2'b01, 2'b00, 9'h010, 9'h000, '0, '0);
    pushg(2'b01, 1'b0, 9'h010, '0);
    pushr(2'b01, 40'h1234567890);
    tick();
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    rsp_ready = 2'b00;
    set_req(2'b10, 2'b00, 9'h000, 9'h021, '0, '0);
    pushg(2'b10, 1'b0, 9'h021, '0);
    tick();
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    reset = 1'b1;
    #1 chk("t5_rsp_before_rst", {38'b0, rsp_valid}, 40'h2);
    tick();
    reset = 1'b0;
    #1 chk("t5_rsp_dropped", {38'b0, rsp_valid}, 40'h0);
    rsp_ready = 2'b11;
    set_req(2'b10, 2'b00, 9'h000, 9'h005, '0, '0);
    pushg(2'b10, 1'b0, 9'h005, '0);
    pushr(2'b10, 40'hAA55AA55AA);
    tick();
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    set_req(2'b11, 2'b01, 9'h000, 9'h1FF, 40'h0F0F0F0F0F, '0);
    pushg(2'b01, 1'b1, 9'h000, 40'h0F0F0F0F0F);
    tick();
    set_req(2'b10, 2'b00, 9'h000, 9'h1FF, '0, '0);
    pushg(2'b10, 1'b0, 9'h1FF, '0);
    pushr(2'b10, 40'hC0000001FF);
    tick();
    set_req(2'b10, 2'b00, 9'h000, 9'h000, '0, '0);
    pushg(2'b10, 1'b0, 9'h000, '0);
    pushr(2'b10, 40'h0F0F0F0F0F);
    tick();
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    repeat (3) tick();
    chk("grants_left", 40'(gq.size()), 40'h0);
    chk("rsps_left", 40'(rq.size()), 40'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
